ring_grant_ctl: RTL and testbench

RING_GRANT_CTL -- requirements
Module: ring_grant_ctl

---
 rtl/ring_grant_ctl_pkg.sv | 18 +
 rtl/ring_grant_ctl_rr_pick.sv | 30 +++
 rtl/ring_grant_ctl.sv | 122 ++++++++++++
 tb/tb_ring_grant_ctl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_grant_ctl_pkg.sv
// Shared definitions for the ring grant controller: default port count,
// FSM state encoding and the index-width helper used for owner/pointer buses.
package ring_grant_ctl_pkg;

    localparam int RGC_NUM_PORTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } rgc_state_e;

    // Width of a port index; kept at least 1 so single-port builds stay legal.
    function automatic int rgc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ring_grant_ctl_rr_pick.sv
// Combinational round-robin search: first set request at or after the pointer,
// scanning upward with wrap-around.
module rr_pick
    import ring_grant_ctl_pkg::*;
#(
    parameter int NUM_PORTS = RGC_NUM_PORTS,
    localparam int OW = rgc_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [OW-1:0]        ptr,
    output logic [OW-1:0]        winner,
    output logic                 valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (!valid && req[idx[OW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[OW-1:0];
            end
        end
    end

endmodule

// File: rtl/ring_grant_ctl.sv
// Ring bus grant controller: round-robin arbitration in IDLE, bounded-length
// grant with release/timeout, then a fixed idle gap before re-arbitrating.
module ring_grant_ctl
    import ring_grant_ctl_pkg::*;
#(
    parameter int NUM_PORTS = RGC_NUM_PORTS,
    parameter int MAX_HOLD  = 64,
    parameter int GAP_CYC   = 2,
    localparam int OW = rgc_idx_w(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] rarb_req,
    input  logic [NUM_PORTS-1:0] rarb_rel,
    output logic [NUM_PORTS-1:0] rarb_ack,
    output logic [OW-1:0]        rarb_owner,
    output logic                 rarb_busy,
    output logic                 rarb_tmo
);

    localparam int HW = rgc_idx_w(MAX_HOLD);
    localparam int GW = rgc_idx_w(GAP_CYC);

    rgc_state_e           state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        rr_q, rr_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 busy_q, busy_d;
    logic                 tmo_q, tmo_d;
    logic                 grant_end;
    logic [OW-1:0]        pick_idx;
    logic                 pick_vld;

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
        .req    (rarb_req),
        .ptr    (rr_q),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            ack_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            ack_q   <= ack_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        ack_d     = ack_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        tmo_d     = 1'b0;
        grant_end = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    ack_d   = NUM_PORTS'(1) << pick_idx;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                // Release has priority over a timeout landing in the same cycle.
                if (rarb_rel[owner_q] || !rarb_req[owner_q]) begin
                    grant_end = 1'b1;
                end else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    grant_end = 1'b1;
                    tmo_d     = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_end) begin
            ack_d   = '0;
            hold_d  = '0;
            gap_d   = '0;
            rr_d    = (owner_q == OW'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
            state_d = (GAP_CYC == 0) ? ST_IDLE : ST_DRAIN;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign rarb_ack   = ack_q;
    assign rarb_owner = owner_q;
    assign rarb_busy  = busy_q;
    assign rarb_tmo   = tmo_q;

endmodule

// File: tb/tb_ring_grant_ctl.sv
// Randomized and directed bench for ring_grant_ctl against a transaction-level
// reference model of the grant/gap/round-robin rules.
module tb_ring_grant_ctl;

    localparam int NP  = 4;
    localparam int MH  = 64;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] req;
    logic [NP-1:0] rel;
    logic [NP-1:0] ack;
    logic [1:0]    owner;
    logic          busy;
    logic          tmo;

    int n_tests = 0;
    int n_fail  = 0;
    int tcount  = 0;

    // Reference model: current grantee (-1 when none), grant cycles elapsed,
    // remaining idle-gap cycles, round-robin pointer, last grantee.
    int m_own, m_held, m_gap, m_ptr, m_last;
    bit m_tmo;

    always #5 clk = ~clk;

    ring_grant_ctl #(.NUM_PORTS(NP), .MAX_HOLD(MH), .GAP_CYC(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .rarb_req   (req),
        .rarb_rel   (rel),
        .rarb_ack   (ack),
        .rarb_owner (owner),
        .rarb_busy  (busy),
        .rarb_tmo   (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_last = 0; m_tmo = 1'b0;
    endtask

    task automatic model_end();
        m_ptr = (m_own + 1) % NP;
        m_own = -1;
        m_gap = GAP;
    endtask

    task automatic model_step();
        bit found;
        m_tmo = 1'b0;
        found = 1'b0;
        if (m_own >= 0) begin
            m_held++;
            if (rel[m_own] || !req[m_own]) model_end();
            else if (m_held == MH) begin
                model_end();
                m_tmo = 1'b1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_ptr + k) % NP;
                if (!found && req[p]) begin
                    found  = 1'b1;
                    m_own  = p;
                    m_last = p;
                    m_held = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        logic [31:0] e_ack;
        e_ack = (m_own >= 0) ? (32'd1 << m_own) : 32'd0;
        chk({ctx, ".ack"},   32'(ack),   e_ack);
        chk({ctx, ".owner"}, 32'(owner), 32'(m_last));
        chk({ctx, ".busy"},  32'(busy),  32'((m_own >= 0) || (m_gap > 0)));
        chk({ctx, ".tmo"},   32'(tmo),   32'(m_tmo));
    endtask

    task automatic tick(input string ctx);
        @(posedge clk);
        model_step();
        tcount++;
        #1;
        check_all(ctx);
    endtask

    // Reset asserted mid-cycle, checked before any clock edge, released after one edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk);
        #1 reset = 1'b1;
        tcount = 0;
    endtask

    task automatic wait_ack(input string ctx);
        int w;
        w = 0;
        while (ack == '0 && w < 50) begin
            tick(ctx);
            w++;
        end
        chk({ctx, ".wait_ack"}, 32'(ack != '0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, cnt;
        reset = 1'b1;
        req   = '0;
        rel   = '0;
        model_reset();
        do_reset();

        // Single requester, release at cycle 10, gap of two.
        req = 4'b0001;
        for (int c = 1; c <= 10; c++) begin
            tick("single");
            chk("single.ack_on", 32'(ack), 32'h1);
        end
        rel = 4'b0001;
        tick("single");
        chk("single.ack_off", 32'(ack), 32'h0);
        rel = '0;
        req = '0;
        tick("single");
        chk("single.busy12", 32'(busy), 32'h1);
        tick("single");
        chk("single.busy13", 32'(busy), 32'h0);

        // Fairness with all ports requesting, 5-cycle grants.
        do_reset();
        req  = 4'b1111;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ack("fair");
            chk("fair.order", 32'(owner), 32'(g % NP));
            if (g > 0) chk("fair.period", 32'(tcount - prev), 32'd8);
            prev = tcount;
            repeat (4) tick("fair");
            rel = ack;
            tick("fair");
            rel = '0;
        end
        req = '0;

        // Timeout on port 2 while port 3 waits.
        do_reset();
        req = 4'b0100;
        wait_ack("tmo");
        req = 4'b1100;
        cnt = 1;
        while (ack == 4'b0100 && cnt < 100) begin
            tick("tmo");
            if (ack == 4'b0100) cnt++;
        end
        chk("tmo.len", 32'(cnt), 32'd64);
        chk("tmo.pulse", 32'(tmo), 32'd1);
        chk("tmo.ack0", 32'(ack), 32'd0);
        wait_ack("tmo");
        chk("tmo.next", 32'(owner), 32'd3);
        req = '0;
        repeat (4) tick("tmo");

        // Release coinciding with the last allowed hold cycle.
        do_reset();
        req = 4'b0001;
        wait_ack("reltmo");
        repeat (63) tick("reltmo");
        rel = 4'b0001;
        tick("reltmo");
        rel = '0;
        chk("reltmo.tmo", 32'(tmo), 32'd0);
        chk("reltmo.ack", 32'(ack), 32'd0);
        chk("reltmo.busy", 32'(busy), 32'd1);
        req = '0;

        // Reset in the middle of a grant, then pointer restarts at 0.
        do_reset();
        req = 4'b0001;
        wait_ack("midrst");
        repeat (6) tick("midrst");
        chk("midrst.pre", 32'(ack), 32'd1);
        req = 4'b1010;
        do_reset();
        tick("midrst");
        chk("midrst.first", 32'(ack), 32'h2);
        req = '0;

        // Spurious non-owner release and owner request drop.
        do_reset();
        req = 4'b0001;
        wait_ack("spur");
        rel = 4'b0100;
        tick("spur");
        rel = '0;
        tick("spur");
        tick("spur");
        chk("spur.c4", 32'(ack), 32'h1);
        req = '0;
        tick("spur");
        chk("spur.c5", 32'(ack), 32'h0);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
                rel[i] = ($urandom_range(5) == 0);
            end
            if ($urandom_range(699) == 0) do_reset();
            else tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
